// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-stage types and constants.
// Used by the fetch controller, its redirect latch and interface.
package fetch_ctrl_pkg;

  localparam int XLEN       = 32;
  localparam int PC_STEP    = 4;
  localparam int ALIGN_MASK = 3;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    WAIT,
    HALTED
  } state_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus: pipeline inputs and PC/hazard controls.
// master = controller side, slave = pipeline/memory side.
interface fetch_ctrl_if
  import fetch_ctrl_pkg::*;
#(
  parameter int WIDTH = XLEN
);

  logic [WIDTH-1:0] PC;
  logic             imem_ready;
  logic             ld_use;
  logic             br_taken;
  logic [WIDTH-1:0] br_target;
  logic             trap_req;
  logic [WIDTH-1:0] trap_vec;
  logic             halt;
  logic [WIDTH-1:0] PCnext;
  logic             PC_nEN;
  logic             IFID_nEN;
  logic             IFID_flush;
  logic             IDEX_flush;
  logic             imem_req;
  logic             redir_pend;

  modport master (
    input  PC, imem_ready, ld_use,
    input  br_taken, br_target,
    input  trap_req, trap_vec, halt,
    output PCnext, PC_nEN, IFID_nEN,
    output IFID_flush, IDEX_flush,
    output imem_req, redir_pend
  );

  modport slave (
    output PC, imem_ready, ld_use,
    output br_taken, br_target,
    output trap_req, trap_vec, halt,
    input  PCnext, PC_nEN, IFID_nEN,
    input  IFID_flush, IDEX_flush,
    input  imem_req, redir_pend
  );

endinterface

// File: rtl/fetch_ctrl_redir_latch.sv
// Holds a redirect that arrived while a fetch was outstanding.
// Traps win over branches; same class replaces the older one.
module redir_latch
  import fetch_ctrl_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clr,
  input  logic             is_trap,
  input  logic [WIDTH-1:0] target,
  output logic             pend,
  output logic             pend_trap,
  output logic [WIDTH-1:0] pend_target
);

  logic take;

  // Only a branch arriving over a pending trap is dropped.
  assign take = !pend || is_trap || !pend_trap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend        <= 1'b0;
      pend_trap   <= 1'b0;
      pend_target <= '0;
    end else if (load) begin
      pend <= 1'b1;
      if (take) begin
        pend_target <= target;
        pend_trap   <= is_trap;
      end
    end else if (clr) begin
      pend      <= 1'b0;
      pend_trap <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// RV32I fetch-stage controller: PC sequencing, redirect
// arbitration, imem handshake and IF/ID, ID/EX controls.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic  CLK,
  input  logic  nRST,
  fetch_ctrl_if.master bus
);

  state_t           state;
  state_t           state_nx;
  logic             redir;
  logic             ld_pend;
  logic             clr_pend;
  logic             pend;
  logic             pend_trap;
  logic [WIDTH-1:0] tgt;
  logic [WIDTH-1:0] pend_tgt;
  logic [WIDTH-1:0] step_pc;
  logic [WIDTH-1:0] mask;

  assign mask    = ~WIDTH'(ALIGN_MASK);
  assign redir   = bus.trap_req | bus.br_taken;
  assign step_pc = bus.PC + WIDTH'(PC_STEP);
  assign tgt     = (bus.trap_req ? bus.trap_vec
                                 : bus.br_target) & mask;

  assign bus.redir_pend = pend;

  redir_latch #(.WIDTH(WIDTH)) u_latch (
    .clk        (CLK),
    .rst_n      (nRST),
    .load       (ld_pend),
    .clr        (clr_pend),
    .is_trap    (bus.trap_req),
    .target     (tgt),
    .pend       (pend),
    .pend_trap  (pend_trap),
    .pend_target(pend_tgt)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= BOOT;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    bus.PCnext     = '0;
    bus.PC_nEN     = 1'b1;
    bus.IFID_nEN   = 1'b1;
    bus.IFID_flush = 1'b1;
    bus.IDEX_flush = 1'b1;
    bus.imem_req   = 1'b0;
    ld_pend        = 1'b0;
    clr_pend       = 1'b0;
    unique case (state)
      BOOT: state_nx = RUN;
      RUN, WAIT: begin
        if (bus.halt) begin
          state_nx       = HALTED;
          bus.IFID_nEN   = 1'b0;
          bus.IDEX_flush = 1'b0;
        end else begin
          bus.imem_req   = 1'b1;
          bus.PCnext     = step_pc;
          bus.IFID_nEN   = 1'b0;
          bus.IFID_flush = 1'b0;
          bus.IDEX_flush = 1'b0;
          if (bus.imem_ready) begin
            state_nx = RUN;
            if (pend) begin
              // Returned word belongs to the old path.
              clr_pend       = 1'b1;
              bus.PC_nEN     = 1'b0;
              bus.IFID_flush = 1'b1;
              bus.IDEX_flush = redir;
              bus.PCnext     = (bus.trap_req ||
                               (bus.br_taken && !pend_trap))
                             ? tgt : pend_tgt;
            end else if (redir) begin
              bus.PC_nEN     = 1'b0;
              bus.PCnext     = tgt;
              bus.IFID_flush = 1'b1;
              bus.IDEX_flush = 1'b1;
            end else if (bus.ld_use) begin
              bus.IFID_nEN   = 1'b1;
              bus.IDEX_flush = 1'b1;
            end else begin
              bus.PC_nEN = 1'b0;
            end
          end else begin
            state_nx = WAIT;
            if (redir) begin
              ld_pend        = 1'b1;
              bus.IFID_flush = 1'b1;
              bus.IDEX_flush = 1'b1;
            end else if (bus.ld_use) begin
              bus.IFID_nEN   = 1'b1;
              bus.IDEX_flush = 1'b1;
            end else begin
              bus.IFID_flush = 1'b1;
            end
          end
        end
      end
      HALTED: begin
        bus.IFID_nEN   = 1'b0;
        bus.IDEX_flush = 1'b0;
      end
      default: state_nx = BOOT;
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus
// randomized traffic against a rule-level reference model.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  logic CLK;
  logic nRST;
  int   errors;
  int   checks;
  logic [31:0] pc_exp;

  fetch_ctrl_if #(.WIDTH(32)) bus ();

  fetch_ctrl #(.WIDTH(32)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  // PC register owned by the bench's pipeline model
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)            bus.PC <= '0;
    else if (!bus.PC_nEN) bus.PC <= bus.PCnext;
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  task automatic next_cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  task automatic quiet();
    bus.ld_use    = 1'b0;
    bus.br_taken  = 1'b0;
    bus.br_target = '0;
    bus.trap_req  = 1'b0;
    bus.trap_vec  = '0;
    bus.halt      = 1'b0;
  endtask

  function automatic logic [5:0] ctl_vec();
    return {bus.PC_nEN, bus.IFID_nEN, bus.IFID_flush,
            bus.IDEX_flush, bus.imem_req, bus.redir_pend};
  endfunction

  task automatic test_reset();
    nRST = 1'b0;
    quiet();
    bus.imem_ready = 1'b1;
    repeat (2) @(posedge CLK);
    mid();
    checks++;
    if (ctl_vec() !== 6'b111100 || bus.PCnext !== 32'h0) begin
      errors++;
      $display("FAIL reset_vals: got %b/%h want 111100/0",
               ctl_vec(), bus.PCnext);
    end
    @(posedge CLK);
    #1 nRST = 1'b1;
    mid();
    checks++;
    if (bus.imem_req !== 1'b0 || bus.PC !== 32'h0) begin
      errors++;
      $display("FAIL boot: req=%b pc=%h want 0/0",
               bus.imem_req, bus.PC);
    end
    for (int i = 0; i < 4; i++) begin
      next_cyc();
      mid();
      checks++;
      if (bus.imem_req !== 1'b1 || bus.PC !== 32'(i * 4)) begin
        errors++;
        $display("FAIL seq%0d: req=%b pc=%h want 1/%h",
                 i, bus.imem_req, bus.PC, i * 4);
      end
    end
  endtask

  task automatic test_branch();
    next_cyc();
    bus.br_taken  = 1'b1;
    bus.br_target = 32'h43;
    mid();
    checks++;
    if (bus.PC !== 32'h10 || bus.IFID_flush !== 1'b1 ||
        bus.IDEX_flush !== 1'b1 || bus.PC_nEN !== 1'b0) begin
      errors++;
      $display("FAIL branch_cyc: pc=%h fl=%b%b nen=%b want 10/11/0",
               bus.PC, bus.IFID_flush, bus.IDEX_flush, bus.PC_nEN);
    end
    next_cyc();
    quiet();
    mid();
    checks++;
    if (bus.PC !== 32'h40) begin
      errors++;
      $display("FAIL branch_pc: got %h want 40", bus.PC);
    end
  endtask

  task automatic test_load_use();
    next_cyc();
    bus.br_taken  = 1'b1;
    bus.br_target = 32'h20;
    next_cyc();
    quiet();
    bus.ld_use = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mid();
      checks++;
      if (bus.PC !== 32'h20 || bus.PC_nEN !== 1'b1 ||
          bus.IFID_nEN !== 1'b1 || bus.IDEX_flush !== 1'b1) begin
        errors++;
        $display("FAIL ld_use%0d: pc=%h nen=%b%b idex=%b want 20/11/1",
                 i, bus.PC, bus.PC_nEN, bus.IFID_nEN, bus.IDEX_flush);
      end
      next_cyc();
    end
    bus.ld_use = 1'b0;
    mid();
    next_cyc();
    mid();
    checks++;
    if (bus.PC !== 32'h24) begin
      errors++;
      $display("FAIL ld_use_after: got %h want 24", bus.PC);
    end
  endtask

  task automatic test_wait_redirect();
    next_cyc();
    bus.imem_ready = 1'b0;
    mid();
    checks++;
    if (bus.PC !== 32'h28 || bus.imem_req !== 1'b1 ||
        bus.PC_nEN !== 1'b1 || bus.IFID_flush !== 1'b1) begin
      errors++;
      $display("FAIL miss: pc=%h req=%b nen=%b fl=%b want 28/1/1/1",
               bus.PC, bus.imem_req, bus.PC_nEN, bus.IFID_flush);
    end
    next_cyc();
    bus.br_taken  = 1'b1;
    bus.br_target = 32'h80;
    mid();
    checks++;
    if (bus.IFID_flush !== 1'b1 || bus.IDEX_flush !== 1'b1 ||
        bus.redir_pend !== 1'b0 || bus.PC !== 32'h28) begin
      errors++;
      $display("FAIL wait_br: fl=%b%b pend=%b pc=%h want 11/0/28",
               bus.IFID_flush, bus.IDEX_flush, bus.redir_pend, bus.PC);
    end
    next_cyc();
    quiet();
    bus.trap_req = 1'b1;
    bus.trap_vec = 32'h100;
    mid();
    checks++;
    if (bus.redir_pend !== 1'b1 || bus.imem_req !== 1'b1) begin
      errors++;
      $display("FAIL wait_trap: pend=%b req=%b want 1/1",
               bus.redir_pend, bus.imem_req);
    end
    next_cyc();
    quiet();
    bus.imem_ready = 1'b1;
    mid();
    checks++;
    if (bus.PCnext !== 32'h100 || bus.PC_nEN !== 1'b0 ||
        bus.IFID_flush !== 1'b1 || bus.PC !== 32'h28) begin
      errors++;
      $display("FAIL wait_ready: nxt=%h nen=%b fl=%b pc=%h want 100/0/1/28",
               bus.PCnext, bus.PC_nEN, bus.IFID_flush, bus.PC);
    end
    next_cyc();
    mid();
    checks++;
    if (bus.PC !== 32'h100 || bus.redir_pend !== 1'b0) begin
      errors++;
      $display("FAIL wait_after: pc=%h pend=%b want 100/0",
               bus.PC, bus.redir_pend);
    end
  endtask

  task automatic test_trap_vs_branch();
    next_cyc();
    bus.trap_req  = 1'b1;
    bus.trap_vec  = 32'h200;
    bus.br_taken  = 1'b1;
    bus.br_target = 32'h300;
    next_cyc();
    quiet();
    mid();
    checks++;
    if (bus.PC !== 32'h200) begin
      errors++;
      $display("FAIL trap_vs_br: got %h want 200", bus.PC);
    end
  endtask

  task automatic test_wrap();
    next_cyc();
    bus.br_taken  = 1'b1;
    bus.br_target = 32'hFFFF_FFFF;
    next_cyc();
    quiet();
    mid();
    checks++;
    if (bus.PC !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL align: got %h want fffffffc", bus.PC);
    end
    next_cyc();
    mid();
    checks++;
    if (bus.PC !== 32'h0) begin
      errors++;
      $display("FAIL wrap: got %h want 0", bus.PC);
    end
    pc_exp = 32'h4;
  endtask

  task automatic test_random();
    logic        rdy, lu, br, tr;
    logic [31:0] bt, tv;
    logic        pv, pt;
    logic [31:0] ptgt;
    pv   = 1'b0;
    pt   = 1'b0;
    ptgt = '0;
    for (int n = 0; n < 400; n++) begin
      next_cyc();
      rdy = ($urandom_range(0, 3) != 0);
      lu  = ($urandom_range(0, 5) == 0);
      br  = ($urandom_range(0, 5) == 0);
      tr  = ($urandom_range(0, 9) == 0);
      bt  = $urandom;
      tv  = $urandom;
      bus.imem_ready = rdy;
      bus.ld_use     = lu;
      bus.br_taken   = br;
      bus.br_target  = bt;
      bus.trap_req   = tr;
      bus.trap_vec   = tv;
      mid();
      checks++;
      if (bus.PC !== pc_exp || bus.imem_req !== 1'b1 ||
          bus.redir_pend !== pv) begin
        errors++;
        $display("FAIL rnd%0d_pc: pc=%h req=%b pend=%b want %h/1/%b",
                 n, bus.PC, bus.imem_req, bus.redir_pend, pc_exp, pv);
      end
      if (rdy && (pv || tr || br)) begin
        checks++;
        if (bus.PC_nEN !== 1'b0 || bus.IFID_flush !== 1'b1) begin
          errors++;
          $display("FAIL rnd%0d_redir: nen=%b fl=%b want 0/1",
                   n, bus.PC_nEN, bus.IFID_flush);
        end
        if (tr) pc_exp = tv & ~32'h3;
        else if (br && !(pv && pt)) pc_exp = bt & ~32'h3;
        else pc_exp = ptgt;
        pv = 1'b0;
      end else if (rdy && lu) begin
        checks++;
        if (bus.PC_nEN !== 1'b1 || bus.IFID_nEN !== 1'b1 ||
            bus.IDEX_flush !== 1'b1 || bus.IFID_flush !== 1'b0) begin
          errors++;
          $display("FAIL rnd%0d_lu: got %b want 1110",
                   n, {bus.PC_nEN, bus.IFID_nEN,
                       bus.IDEX_flush, bus.IFID_flush});
        end
      end else if (rdy) begin
        checks++;
        if (bus.PC_nEN !== 1'b0 || bus.IFID_nEN !== 1'b0 ||
            bus.IFID_flush !== 1'b0 || bus.IDEX_flush !== 1'b0) begin
          errors++;
          $display("FAIL rnd%0d_seq: got %b want 0000",
                   n, {bus.PC_nEN, bus.IFID_nEN,
                       bus.IFID_flush, bus.IDEX_flush});
        end
        pc_exp = pc_exp + 32'd4;
      end else if (tr || br) begin
        checks++;
        if (bus.PC_nEN !== 1'b1 || bus.IFID_flush !== 1'b1 ||
            bus.IDEX_flush !== 1'b1) begin
          errors++;
          $display("FAIL rnd%0d_missredir: got %b want 111",
                   n, {bus.PC_nEN, bus.IFID_flush, bus.IDEX_flush});
        end
        if (!pv || tr || !pt) begin
          ptgt = (tr ? tv : bt) & ~32'h3;
          pt   = tr;
        end
        pv = 1'b1;
      end else if (lu) begin
        checks++;
        if (bus.PC_nEN !== 1'b1 || bus.IFID_nEN !== 1'b1 ||
            bus.IDEX_flush !== 1'b1 || bus.IFID_flush !== 1'b0) begin
          errors++;
          $display("FAIL rnd%0d_misslu: got %b want 1110",
                   n, {bus.PC_nEN, bus.IFID_nEN,
                       bus.IDEX_flush, bus.IFID_flush});
        end
      end else begin
        checks++;
        if (bus.PC_nEN !== 1'b1 || bus.IFID_flush !== 1'b1) begin
          errors++;
          $display("FAIL rnd%0d_miss: nen=%b fl=%b want 1/1",
                   n, bus.PC_nEN, bus.IFID_flush);
        end
      end
    end
  endtask

  task automatic test_halt();
    next_cyc();
    quiet();
    bus.imem_ready = 1'b1;
    bus.halt       = 1'b1;
    mid();
    checks++;
    if (bus.imem_req !== 1'b0 || bus.PC_nEN !== 1'b1 ||
        bus.PC !== pc_exp) begin
      errors++;
      $display("FAIL halt: req=%b nen=%b pc=%h want 0/1/%h",
               bus.imem_req, bus.PC_nEN, bus.PC, pc_exp);
    end
    next_cyc();
    bus.halt      = 1'b0;
    bus.br_taken  = 1'b1;
    bus.br_target = 32'h500;
    mid();
    next_cyc();
    quiet();
    mid();
    checks++;
    if (bus.imem_req !== 1'b0 || bus.PC !== pc_exp ||
        bus.redir_pend !== 1'b0 || bus.IFID_flush !== 1'b1) begin
      errors++;
      $display("FAIL halted: req=%b pc=%h pend=%b fl=%b want 0/%h/0/1",
               bus.imem_req, bus.PC, bus.redir_pend,
               bus.IFID_flush, pc_exp);
    end
  endtask

  task automatic test_async_reset();
    #2 nRST = 1'b0;
    #1;
    checks++;
    if (ctl_vec() !== 6'b111100 || bus.PCnext !== 32'h0 ||
        bus.PC !== 32'h0) begin
      errors++;
      $display("FAIL async_rst1: got %b/%h/%h want 111100/0/0",
               ctl_vec(), bus.PCnext, bus.PC);
    end
    @(posedge CLK);
    #1 nRST = 1'b1;
    next_cyc();
    bus.imem_ready = 1'b0;
    next_cyc();
    bus.br_taken  = 1'b1;
    bus.br_target = 32'h60;
    next_cyc();
    quiet();
    mid();
    checks++;
    if (bus.redir_pend !== 1'b1 || bus.PC !== 32'h0) begin
      errors++;
      $display("FAIL pre_rst: pend=%b pc=%h want 1/0",
               bus.redir_pend, bus.PC);
    end
    #2 nRST = 1'b0;
    #1;
    checks++;
    if (ctl_vec() !== 6'b111100 || bus.PCnext !== 32'h0) begin
      errors++;
      $display("FAIL async_rst2: got %b/%h want 111100/0",
               ctl_vec(), bus.PCnext);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    pc_exp = '0;
    test_reset();
    test_branch();
    test_load_use();
    test_wait_redirect();
    test_trap_vs_branch();
    test_wrap();
    test_random();
    test_halt();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-stage controller for the RV32I pipeline. Sequences the program-counter register by generating its next value and its active-low enable. Arbitrates between trap entry, branch/jump redirect, load-use stall and sequential fetch. Also runs the instruction-memory request handshake and drives the IF/ID and ID/EX enable/flush controls.

## Interface
- WIDTH, 32, address/PC width
- CLK  in  1  clock; all state updates on rising edge
- nRST  in  1  asynchronous, active-low reset
- PC  in  WIDTH  current value of the PC register
- imem_ready  in  1  instruction memory returns data this cycle (completes `imem_req`)
- ld_use  in  1  load-use hazard detected in ID
- br_taken  in  1  EX resolved a taken branch or jump
- br_target  in  WIDTH  EX redirect address
- trap_req  in  1  trap entry requested (ecall/ebreak/illegal)
- trap_vec  in  WIDTH  trap handler address
- halt  in  1  stop fetching
- PCnext  out  WIDTH  next PC to the PC register
- PC_nEN  out  1  0 = PC register loads `PCnext`; 1 = PC holds
- IFID_nEN  out  1  0 = IF/ID loads; 1 = IF/ID holds
- IFID_flush  out  1  IF/ID captures a bubble
- IDEX_flush  out  1  ID/EX captures a bubble
- imem_req  out  1  fetch request at address `PC`
- redir_pend  out  1  a redirect is latched and waiting for the memory

## Operation
- **States**
  - BOOT: entered on reset; one cycle.
  - RUN: normal fetch.
  - WAIT: fetch outstanding, `imem_ready` low.
  - HALTED: terminal.
- **Transitions**
  - BOOT -> RUN unconditionally.
  - RUN -> WAIT when `imem_req` and not `imem_ready`.
  - WAIT -> RUN on `imem_ready`.
  - RUN or WAIT -> HALTED on `halt`; HALTED is left only by reset.
- **Redirect targets:** `trap_vec` and `br_target` have bits[1:0] forced to 0 before use.
- **RUN priority, applied on an `imem_ready` cycle**
  1. `trap_req`: `PCnext` = `trap_vec`.
  2. `br_taken`: `PCnext` = `br_target`.
  3. `ld_use`: `PC_nEN` = 1.
  4. Otherwise: `PCnext` = `PC` + 4, modulo 2^WIDTH.
- **Redirect (trap or branch):** `PC_nEN` = 0, `IFID_flush` = 1, `IDEX_flush` = 1, all in the same cycle.
- **Load-use:** `PC_nEN` = 1, `IFID_nEN` = 1, `IDEX_flush` = 1.
- **Memory not ready, no `ld_use`:** `PC_nEN` = 1, `IFID_flush` = 1; the bubble lets downstream drain.
- **Memory not ready with `ld_use`:** `IFID_nEN` = 1 and `IDEX_flush` = 1; the held IF/ID must not be flushed.
- **Redirect while not ready (RUN miss cycle or WAIT)**
  - Latch the target into `pend_target` and set `redir_pend`.
  - Assert both flushes in that cycle.
  - On the `imem_ready` cycle: discard the returned instruction (`IFID_flush` = 1), drive `PCnext` = `pend_target` with `PC_nEN` = 0, then clear `redir_pend`.
- **Pending overwrite rules**
  - A trap overwrites a pending branch.
  - A branch does not overwrite a pending trap.
  - A newer request of equal class overwrites.
- **HALTED:** `imem_req` = 0, `PC_nEN` = 1, `IFID_flush` = 1; redirects are ignored.
- **Arbitration in BOOT:** `ld_use`, `br_taken` and `trap_req` are ignored.

## Timing
- **Output reset values, while `nRST` = 0**
  - `PC_nEN` = 1, `IFID_nEN` = 1
  - `IFID_flush` = 1, `IDEX_flush` = 1
  - `imem_req` = 0, `redir_pend` = 0
  - `PCnext` = 0
- **Registered state:** state, `redir_pend`, `pend_target`, `pend_is_trap`. All clear asynchronously on `nRST` low.
- **Combinational (Mealy) outputs:** `PCnext`, `PC_nEN`, `IFID_nEN`, flushes and `imem_req`, from state, pending registers and inputs. No added latency.
- **Redirect latency:** redirect asserted in cycle N with `imem_ready` high -> `PC` = target after edge N+1 edge, i.e. visible in cycle N+1.
- **Redirect in WAIT:** the target is applied in the cycle `imem_ready` rises.
- **BOOT:** exactly one cycle after `nRST` deasserts, with `imem_req` = 0. The first fetch is at `PC` = 0 in the next cycle.
- **Memory handshake:** `imem_req` stays high and `PC` stays stable from the first request cycle until `imem_ready`. A request is never withdrawn except by `halt` or reset.
- **Reset mid-WAIT:** the outstanding fetch is abandoned; the memory is expected to be reset by the same `nRST`.

## Structure
- **Shared pipeline package:** state enum (BOOT/RUN/WAIT/HALTED), the `PC_STEP` = 4 constant, and the alignment mask.
- **Sub-module:** one, `redir_latch`, holding `pend_target`, `redir_pend`, `pend_is_trap` and the overwrite rules.
- **Top level:** the FSM and output decode.

## Test plan
- **Reset and boot:** release `nRST` with `imem_ready` = 1 -> one BOOT cycle with `imem_req` = 0, then `PC` = 0, 4, 8, 0xC on successive cycles.
- **Branch in RUN:** at `PC` = 0x10, pulse `br_taken`, `br_target` = 0x43 -> same cycle both flushes = 1; next cycle `PC` = 0x40.
- **Load-use for two cycles:** `PC` holds 0x20 for two cycles; `IFID_nEN` = 1 and `IDEX_flush` = 1 both cycles; then `PC` = 0x24.
- **Redirect during WAIT:** `imem_ready` = 0 for 3 cycles; `br_taken` (0x80) arrives in cycle 1 and `trap_req` (0x100) in cycle 2 -> `redir_pend` = 1; on ready `PC` becomes 0x100 and the returned instruction is flushed.
- **Trap vs branch same cycle:** `trap_vec` = 0x200, `br_target` = 0x300 -> `PC` = 0x200.
- **Halt and async reset:** assert `halt` -> `imem_req` = 0 and `PC` frozen. Pulse `nRST` low mid-cycle -> outputs at reset values immediately, without waiting for a clock edge.
